// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU operation issuer.
package alu_issue_pkg;
  localparam int DW      = 8;   // operand width
  localparam int CW      = 4;   // command width
  localparam int TW      = 4;   // tag width
  localparam int GW      = 5;   // split gap counter width
  localparam int ALU_WIN = 16;  // ALU's operand-pairing window in cycles

  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_BEAT1, ST_GAP, ST_BEAT2, ST_WAIT, ST_DONE
  } state_e;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [GW-1:0] gap;
    logic          bfirst;
    logic          split;
    logic          cin;
    logic          mode;
    logic [CW-1:0] cmd;
    logic [DW-1:0] opb;
    logic [DW-1:0] opa;
  } req_t;

  // A split op whose gap reaches the ALU window will make the ALU flag ERR.
  function automatic logic is_timeout(req_t r);
    return r.split && (int'(r.gap) >= ALU_WIN);
  endfunction
endpackage

// File: rtl/alu_issue_if.sv
// Request port, ALU operand port and completion signals of the issuer.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic          REQ_VALID;
  logic          REQ_READY;
  logic [DW-1:0] REQ_OPA;
  logic [DW-1:0] REQ_OPB;
  logic [CW-1:0] REQ_CMD;
  logic          REQ_MODE;
  logic          REQ_CIN;
  logic          REQ_SPLIT;
  logic          REQ_BFIRST;
  logic [GW-1:0] REQ_GAP;
  logic [TW-1:0] REQ_TAG;
  logic [1:0]    INP_VALID;
  logic [DW-1:0] OPA;
  logic [DW-1:0] OPB;
  logic [CW-1:0] CMD;
  logic          MODE;
  logic          CIN;
  logic          CE;
  logic          DONE;
  logic [TW-1:0] DONE_TAG;
  logic          DONE_TO;

  // Issuer side
  modport slave (
    input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN,
           REQ_SPLIT, REQ_BFIRST, REQ_GAP, REQ_TAG,
    output REQ_READY, INP_VALID, OPA, OPB, CMD, MODE, CIN, CE,
           DONE, DONE_TAG, DONE_TO
  );

  // Requester / observer side
  modport master (
    output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN,
           REQ_SPLIT, REQ_BFIRST, REQ_GAP, REQ_TAG,
    input  REQ_READY, INP_VALID, OPA, OPB, CMD, MODE, CIN, CE,
           DONE, DONE_TAG, DONE_TO
  );
endinterface

// File: rtl/alu_issue_fifo.sv
// Request FIFO: wrap-bit pointers, full/empty from pointer compare, sync reset.
module alu_issue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // Pointer state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/alu_op_issuer.sv
// Issue stage: buffers whole ALU ops and replays them as one or two operand
// beats, then pulses DONE once the ALU result is valid.
module alu_op_issuer
  import alu_issue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RES_WAIT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  alu_issue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  req_t          op_q, op_d, in_req, head;
  logic [GW-1:0] cnt_q, cnt_d;
  logic [1:0]    iv_q, iv_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic          mode_q, mode_d, cin_q, cin_d, ce_q;
  logic          done_q, done_d, dto_q, dto_d;
  logic [TW-1:0] dtag_q, dtag_d;
  logic          pop, full, empty;
  logic [AW:0]   count;
  logic [$bits(req_t)-1:0] rdata;

  assign in_req = '{tag: bus.REQ_TAG, gap: bus.REQ_GAP, bfirst: bus.REQ_BFIRST,
                    split: bus.REQ_SPLIT, cin: bus.REQ_CIN, mode: bus.REQ_MODE,
                    cmd: bus.REQ_CMD, opb: bus.REQ_OPB, opa: bus.REQ_OPA};
  assign head   = req_t'(rdata);

  alu_issue_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i(CLK), .rst_i(RST), .push_i(bus.REQ_VALID), .pop_i(pop),
    .wdata_i(in_req), .rdata_o(rdata), .full_o(full), .empty_o(empty),
    .count_o(count)
  );

  assign bus.REQ_READY = (count != (AW+1)'(DEPTH));
  assign bus.INP_VALID = iv_q;
  assign bus.OPA       = opa_q;
  assign bus.OPB       = opb_q;
  assign bus.CMD       = cmd_q;
  assign bus.MODE      = mode_q;
  assign bus.CIN       = cin_q;
  assign bus.CE        = ce_q;
  assign bus.DONE      = done_q;
  assign bus.DONE_TAG  = dtag_q;
  assign bus.DONE_TO   = dto_q;

  // Next state; operand outputs are computed one cycle ahead so every beat
  // is registered exactly while its FSM state is current.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    iv_d    = IV_NONE;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    done_d  = 1'b0;
    dtag_d  = dtag_q;
    dto_d   = dto_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE also pops so the next op issues right behind the pulse
        if (!empty) begin
          pop     = 1'b1;
          op_d    = head;
          state_d = ST_BEAT1;
          cmd_d   = head.cmd;
          mode_d  = head.mode;
          cin_d   = head.cin;
          if (!head.split) begin
            iv_d  = IV_AB;
            opa_d = head.opa;
            opb_d = head.opb;
          end else if (head.bfirst) begin
            iv_d  = IV_B;
            opb_d = head.opb;
          end else begin
            iv_d  = IV_A;
            opa_d = head.opa;
          end
        end
      end
      ST_BEAT1: begin
        if (!op_q.split) begin
          state_d = ST_WAIT;
          cnt_d   = GW'(RES_WAIT - 1);
        end else if (op_q.gap != '0) begin
          state_d = ST_GAP;
          cnt_d   = op_q.gap - 1'b1;
        end else begin
          state_d = ST_BEAT2;
          if (op_q.bfirst) begin iv_d = IV_A; opa_d = op_q.opa; end
          else             begin iv_d = IV_B; opb_d = op_q.opb; end
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_BEAT2;
          if (op_q.bfirst) begin iv_d = IV_A; opa_d = op_q.opa; end
          else             begin iv_d = IV_B; opb_d = op_q.opb; end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BEAT2: begin
        state_d = ST_WAIT;
        cnt_d   = GW'(RES_WAIT - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          dtag_d  = op_q.tag;
          dto_d   = is_timeout(op_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; CE stays high so the ALU's own reset works
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      iv_q    <= IV_NONE;
      opa_q   <= '0;
      opb_q   <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      ce_q    <= 1'b1;
      done_q  <= 1'b0;
      dtag_q  <= '0;
      dto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      iv_q    <= iv_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      ce_q    <= 1'b1;
      done_q  <= done_d;
      dtag_q  <= dtag_d;
      dto_q   <= dto_d;
    end
  end
endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a DONE-tag scoreboard.
module tb_alu_op_issuer;
  import alu_issue_pkg::*;

  localparam int RES_WAIT = 3;

  typedef struct {
    logic [TW-1:0] tag;
    logic          to;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_issue_if bus();

  alu_op_issuer #(.DEPTH(4), .RES_WAIT(RES_WAIT)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int            n_chk  = 0;
  int            n_fail = 0;
  exp_t          sb[$];
  logic [TW-1:0] tag_log[$];
  exp_t          mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every DONE must match the oldest accepted request
  always @(negedge CLK) begin
    if (!RST && bus.DONE === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(bus.DONE), 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("done_tag", 32'(bus.DONE_TAG), 32'(mon_e.tag));
        chk("done_to", 32'(bus.DONE_TO), 32'(mon_e.to));
        tag_log.push_back(bus.DONE_TAG);
      end
    end
  end

  function automatic req_t mk(input int tag, input int opa, input int opb, input int cmd,
                              input bit mode, input bit cin, input bit split,
                              input bit bfirst, input int gap);
    req_t r;
    r.tag = TW'(tag); r.opa = DW'(opa); r.opb = DW'(opb); r.cmd = CW'(cmd);
    r.mode = mode; r.cin = cin; r.split = split; r.bfirst = bfirst; r.gap = GW'(gap);
    return r;
  endfunction

  // Called just after a negedge; holds the request across one posedge
  task automatic push(input req_t r, output bit acc);
    bus.REQ_VALID = 1'b1; bus.REQ_OPA = r.opa; bus.REQ_OPB = r.opb;
    bus.REQ_CMD = r.cmd; bus.REQ_MODE = r.mode; bus.REQ_CIN = r.cin;
    bus.REQ_SPLIT = r.split; bus.REQ_BFIRST = r.bfirst; bus.REQ_GAP = r.gap;
    bus.REQ_TAG = r.tag;
    acc = bus.REQ_READY;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    if (acc) sb.push_back('{r.tag, r.split && (int'(r.gap) >= 16)});
  endtask

  // Push into an idle, empty block and check the full beat/DONE timeline
  task automatic run_op(input req_t r, input string nm);
    bit acc;
    int dl, b2;
    logic [1:0] c1, c2, ev;
    push(r, acc);
    chk({nm, "_acc"}, 32'(acc), 32'd1);
    c1 = !r.split ? IV_AB : (r.bfirst ? IV_B : IV_A);
    c2 = r.bfirst ? IV_A : IV_B;
    b2 = r.split ? int'(r.gap) + 1 : -1;
    dl = r.split ? int'(r.gap) + 2 + RES_WAIT : 1 + RES_WAIT;
    for (int i = 0; i <= dl; i++) begin
      @(negedge CLK);
      ev = (i == 0) ? c1 : (i == b2) ? c2 : IV_NONE;
      chk($sformatf("%s_iv%0d", nm, i), 32'(bus.INP_VALID), 32'(ev));
      chk($sformatf("%s_done%0d", nm, i), 32'(bus.DONE), 32'(i == dl));
      chk($sformatf("%s_cmd%0d", nm, i), 32'(bus.CMD), 32'(r.cmd));
      chk($sformatf("%s_mode%0d", nm, i), 32'(bus.MODE), 32'(r.mode));
      chk($sformatf("%s_cin%0d", nm, i), 32'(bus.CIN), 32'(r.cin));
      if (i == 0 && (!r.split || !r.bfirst)) chk({nm, "_opa1"}, 32'(bus.OPA), 32'(r.opa));
      if (i == 0 && (!r.split || r.bfirst))  chk({nm, "_opb1"}, 32'(bus.OPB), 32'(r.opb));
      if (i == b2) begin
        chk({nm, "_opa2"}, 32'(bus.OPA), 32'(r.opa));
        chk({nm, "_opb2"}, 32'(bus.OPB), 32'(r.opb));
      end
    end
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin @(negedge CLK); n++; end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r, ra, rb;
    bit   acc, saw_full, found, act;
    int   tries;
    bus.REQ_VALID = 0; bus.REQ_OPA = 0; bus.REQ_OPB = 0; bus.REQ_CMD = 0;
    bus.REQ_MODE = 0; bus.REQ_CIN = 0; bus.REQ_SPLIT = 0; bus.REQ_BFIRST = 0;
    bus.REQ_GAP = 0; bus.REQ_TAG = 0;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_iv", 32'(bus.INP_VALID), 32'd0);
    chk("rst_opa", 32'(bus.OPA), 32'd0);
    chk("rst_opb", 32'(bus.OPB), 32'd0);
    chk("rst_cmd", 32'(bus.CMD), 32'd0);
    chk("rst_mode", 32'(bus.MODE), 32'd0);
    chk("rst_cin", 32'(bus.CIN), 32'd0);
    chk("rst_ce", 32'(bus.CE), 32'd1);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_dtag", 32'(bus.DONE_TAG), 32'd0);
    chk("rst_dto", 32'(bus.DONE_TO), 32'd0);
    chk("rst_ready", 32'(bus.REQ_READY), 32'd1);
    RST = 1'b0;
    @(negedge CLK);

    // Single-beat ADD, then split variants around the window boundary
    run_op(mk(3, 'hF0, 'h20, 0, 1, 0, 0, 0, 0), "single");
    drain(20);
    run_op(mk(4, 9, 9, 'h8, 0, 0, 1, 0, 5), "splitA5");
    drain(20);
    run_op(mk(5, 'h3C, 'hA5, 2, 1, 1, 1, 1, 16), "splitB16");
    drain(20);
    run_op(mk(6, 'h11, 'h22, 3, 1, 0, 1, 1, 15), "splitB15");
    drain(20);
    run_op(mk(2, 'h7F, 'h01, 1, 1, 1, 1, 0, 0), "splitA0");
    drain(20);

    // Back-pressure: six back-to-back requests into a 4-deep FIFO
    tag_log.delete();
    saw_full = 0;
    for (int t = 0; t < 6; t++) begin
      r = mk(t, t * 16 + 1, t + 2, t, 1, 0, 0, 0, 0);
      tries = 0;
      do begin
        push(r, acc);
        if (!acc) saw_full = 1;
        tries++;
      end while (!acc && tries < 100);
      chk($sformatf("bp_acc%0d", t), 32'(acc), 32'd1);
    end
    drain(200);
    chk("bp_saw_full", 32'(saw_full), 32'd1);
    chk("bp_count", 32'(tag_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < tag_log.size(); i++)
      chk($sformatf("bp_order%0d", i), 32'(tag_log[i]), 32'(i));

    // Reset during GAP with two entries queued
    push(mk(7, 1, 2, 0, 1, 0, 1, 0, 20), acc);
    push(mk(8, 3, 4, 0, 1, 0, 0, 0, 0), acc);
    push(mk(9, 5, 6, 0, 1, 0, 0, 0, 0), acc);
    repeat (2) @(negedge CLK);
    chk("mid_in_gap", 32'(bus.INP_VALID), 32'd0);
    RST = 1'b1;
    sb.delete();
    @(negedge CLK);
    chk("mid_rst_iv", 32'(bus.INP_VALID), 32'd0);
    chk("mid_rst_ce", 32'(bus.CE), 32'd1);
    chk("mid_rst_done", 32'(bus.DONE), 32'd0);
    chk("mid_rst_ready", 32'(bus.REQ_READY), 32'd1);
    RST = 1'b0;
    act = 0;
    repeat (30) begin
      @(negedge CLK);
      if (bus.INP_VALID !== IV_NONE || bus.DONE !== 1'b0) act = 1;
    end
    chk("mid_rst_quiet", 32'(act), 32'd0);
    run_op(mk(10, 'h55, 'hAA, 4, 0, 1, 0, 0, 0), "post_rst");
    drain(20);

    // Back-to-back singles: second beat right after first DONE
    ra = mk(1, 'h12, 'h34, 0, 1, 0, 0, 0, 0);
    rb = mk(2, 'h56, 'h78, 5, 0, 1, 0, 0, 0);
    push(ra, acc);
    push(rb, acc);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1) found = 1;
    end
    chk("b2b_done_seen", 32'(found), 32'd1);
    @(negedge CLK);
    chk("b2b_iv", 32'(bus.INP_VALID), 32'(IV_AB));
    chk("b2b_opa", 32'(bus.OPA), 32'(rb.opa));
    chk("b2b_opb", 32'(bus.OPB), 32'(rb.opb));
    chk("b2b_cmd", 32'(bus.CMD), 32'(rb.cmd));
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
